// File: rtl/el2_pkg.sv
// el2_pkg: shared PMP access-type and arbiter request packet definitions.
package el2_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef struct packed {
        logic rd;
        logic wr;
        logic exec;
    } el2_pmp_type_pkt_t;

    typedef struct packed {
        logic [31:0]            addr;
        el2_pmp_type_pkt_t      acc_type;
        logic [NUM_REQ_MAX-1:0] id;
    } el2_pmp_arb_req_pkt_t;

endpackage

// File: rtl/el2_pmp_arb_rr.sv
// el2_pmp_arb_rr: one-hot grant starting the search at the pointer index, wrapping upward.
module el2_pmp_arb_rr #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        o_gnt = '0;
        for (int k = N - 1; k >= 0; k--)
            o_gnt = i_req[(int'(i_ptr) + k) % N] ? N'(1) << ((int'(i_ptr) + k) % N) : o_gnt;
    end

endmodule

// File: rtl/el2_pmp_arbiter.sv
// el2_pmp_arbiter: shares one PMP check channel between NUM_REQ requesters, 2-cycle response.
// EL2_PMP_ARB_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module el2_pmp_arbiter
    import el2_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [31:0]        req_addr [NUM_REQ],
    input  el2_pmp_type_pkt_t  req_type [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [NUM_REQ-1:0] resp_err,
    output logic [31:0]        pmp_chan_addr,
    output el2_pmp_type_pkt_t  pmp_chan_type,
    input  logic               pmp_chan_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [PW-1:0]        w_ptr;
    logic [PW-1:0]        w_idx;
    logic                 w_hs;
    el2_pmp_arb_req_pkt_t r_s1;
    logic                 r_s1_vld;
    logic                 r_s2_vld;
    logic                 r_s2_err;
    logic [NUM_REQ-1:0]   r_s2_id;

    assign w_req = req_valid & {NUM_REQ{~flush}};
    assign w_hs  = |w_gnt;

    el2_pmp_arb_rr #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_req (w_req),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_idx = w_gnt[i] ? PW'(i) : w_idx;
    end

`ifdef EL2_PMP_ARB_RR_EN
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
    logic [PW-1:0] r_ptr;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_ptr <= '0;
        else if (w_hs)
            r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Stage-1 payload holds when idle; only the valids are killed by flush.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_err <= 1'b0;
            r_s2_id  <= '0;
        end else begin
            r_s1_vld <= w_hs;
            r_s2_vld <= r_s1_vld & ~flush & (|r_s1.id);
            if (w_hs)
                r_s1 <= '{addr: req_addr[w_idx], acc_type: req_type[w_idx], id: NUM_REQ_MAX'(w_gnt)};
            if (r_s1_vld) begin
                r_s2_err <= pmp_chan_err;
                r_s2_id  <= r_s1.id[NUM_REQ-1:0];
            end
        end
    end

    assign req_ready     = w_gnt;
    assign resp_valid    = r_s2_vld ? r_s2_id : '0;
    assign resp_err      = resp_valid & {NUM_REQ{r_s2_err}};
    assign pmp_chan_addr = r_s1.addr;
    assign pmp_chan_type = r_s1.acc_type;

endmodule
